// File: rtl/led_sr_driver.sv
// Serial driver for a 74HC595-style LED chain: accepts one LED word per frame,
// shifts it out on sr_ser/sr_clk at a divided rate, then pulses sr_latch.
module led_sr_driver #(
    parameter int LED_COUNT = 16,
    parameter int CLK_DIV   = 4,
    parameter int MSB_FIRST = 1
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [LED_COUNT-1:0] s_data,
    input  logic                 s_valid,
    output logic                 s_ready,
    output logic                 sr_ser,
    output logic                 sr_clk,
    output logic                 sr_latch,
    output logic                 busy
);

    localparam int DIV_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam int CNT_W = $clog2(LED_COUNT);
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);
    localparam logic [CNT_W-1:0] BIT_LAST = CNT_W'(LED_COUNT - 1);

    typedef enum logic [1:0] {
        IDLE,
        SHIFT_LO,
        SHIFT_HI,
        LATCH
    } state_e;

    state_e                 state_q, state_d;
    logic [DIV_W-1:0]       div_cnt_q, div_cnt_d;
    logic [CNT_W-1:0]       bit_cnt_q, bit_cnt_d;
    logic [LED_COUNT-1:0]   shreg_q, shreg_d;
    logic                   s_ready_q, s_ready_d;
    logic                   sr_ser_q, sr_ser_d;
    logic                   sr_clk_q, sr_clk_d;
    logic                   sr_latch_q, sr_latch_d;
    logic                   phase_done;
    logic                   head_d;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            div_cnt_q  <= '0;
            bit_cnt_q  <= '0;
            shreg_q    <= '0;
            s_ready_q  <= 1'b1;
            sr_ser_q   <= 1'b0;
            sr_clk_q   <= 1'b0;
            sr_latch_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            div_cnt_q  <= div_cnt_d;
            bit_cnt_q  <= bit_cnt_d;
            shreg_q    <= shreg_d;
            s_ready_q  <= s_ready_d;
            sr_ser_q   <= sr_ser_d;
            sr_clk_q   <= sr_clk_d;
            sr_latch_q <= sr_latch_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        div_cnt_d  = div_cnt_q;
        bit_cnt_d  = bit_cnt_q;
        shreg_d    = shreg_q;
        phase_done = (div_cnt_q == DIV_LAST);
        unique case (state_q)
            IDLE: begin
                if (s_valid) begin
                    shreg_d   = s_data;
                    div_cnt_d = '0;
                    bit_cnt_d = '0;
                    state_d   = SHIFT_LO;
                end
            end
            SHIFT_LO: begin
                if (phase_done) begin
                    div_cnt_d = '0;
                    state_d   = SHIFT_HI;
                end else begin
                    div_cnt_d = div_cnt_q + DIV_W'(1);
                end
            end
            SHIFT_HI: begin
                if (phase_done) begin
                    div_cnt_d = '0;
                    if (bit_cnt_q == BIT_LAST) begin
                        state_d = LATCH;
                    end else begin
                        if (MSB_FIRST != 0) begin
                            shreg_d = {shreg_q[LED_COUNT-2:0], 1'b0};
                        end else begin
                            shreg_d = {1'b0, shreg_q[LED_COUNT-1:1]};
                        end
                        bit_cnt_d = bit_cnt_q + CNT_W'(1);
                        state_d   = SHIFT_LO;
                    end
                end else begin
                    div_cnt_d = div_cnt_q + DIV_W'(1);
                end
            end
            LATCH: begin
                if (phase_done) begin
                    div_cnt_d = '0;
                    state_d   = IDLE;
                end else begin
                    div_cnt_d = div_cnt_q + DIV_W'(1);
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Outputs decode the next state so they are registered yet line up with the state they describe.
    always_comb begin
        s_ready_d  = 1'b0;
        sr_ser_d   = 1'b0;
        sr_clk_d   = 1'b0;
        sr_latch_d = 1'b0;
        head_d     = (MSB_FIRST != 0) ? shreg_d[LED_COUNT-1] : shreg_d[0];
        unique case (state_d)
            IDLE:     s_ready_d = 1'b1;
            SHIFT_LO: sr_ser_d  = head_d;
            SHIFT_HI: begin
                sr_ser_d = head_d;
                sr_clk_d = 1'b1;
            end
            LATCH:    sr_latch_d = 1'b1;
            default:  s_ready_d = 1'b0;
        endcase
    end

    assign s_ready  = s_ready_q;
    assign busy     = ~s_ready_q;
    assign sr_ser   = sr_ser_q;
    assign sr_clk   = sr_clk_q;
    assign sr_latch = sr_latch_q;

endmodule

// File: tb/tb_led_sr_driver.sv
// Scoreboard bench for led_sr_driver: instance 0 uses defaults, instance 1 is LSB-first with CLK_DIV=1.
module tb_led_sr_driver;

    typedef struct packed {
        logic [1:0]  inst;
        logic [15:0] word;
    } exp_t;

    logic        clk;
    logic        rst;
    logic [15:0] s_data  [2];
    logic        s_valid [2];
    logic        ready   [2];
    logic        ser     [2];
    logic        sclk    [2];
    logic        latch   [2];
    logic        busy    [2];

    int n_vec;
    int n_bad;
    int cyc;
    exp_t exp_q[$];

    // monitor state per instance
    logic        clk_p  [2];
    logic        lat_p  [2];
    logic        busy_p [2];
    int          hi_run [2];
    int          lo_run [2];
    int          lat_run[2];
    int          edges  [2];
    int          fcyc   [2];
    int          last_rise[2];
    int          prev_rise[2];
    logic [15:0] chain  [2];

    led_sr_driver #(.LED_COUNT(16), .CLK_DIV(4), .MSB_FIRST(1)) dut_a (
        .clk(clk), .rst(rst), .s_data(s_data[0]), .s_valid(s_valid[0]),
        .s_ready(ready[0]), .sr_ser(ser[0]), .sr_clk(sclk[0]),
        .sr_latch(latch[0]), .busy(busy[0])
    );

    led_sr_driver #(.LED_COUNT(16), .CLK_DIV(1), .MSB_FIRST(0)) dut_b (
        .clk(clk), .rst(rst), .s_data(s_data[1]), .s_valid(s_valid[1]),
        .s_ready(ready[1]), .sr_ser(ser[1]), .sr_clk(sclk[1]),
        .sr_latch(latch[1]), .busy(busy[1])
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    function automatic int div_of(input int i);
        return (i == 0) ? 4 : 1;
    endfunction

    task automatic check(input string name, input int act, input int exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    always @(negedge clk) begin
        for (int i = 0; i < 2; i++) begin
            if (rst) begin
                clk_p[i]   = 1'b0;
                lat_p[i]   = 1'b0;
                busy_p[i]  = 1'b0;
                hi_run[i]  = 0;
                lo_run[i]  = 0;
                lat_run[i] = 0;
                edges[i]   = 0;
                fcyc[i]    = 0;
            end else begin
                check("busy_vs_ready", int'(busy[i]), int'(!ready[i]));
                check("clk_latch_excl", int'(sclk[i] & latch[i]), 0);
                if (!busy[i]) check("idle_outputs", int'({ser[i], sclk[i], latch[i]}), 0);
                if (busy[i] && !busy_p[i]) begin
                    edges[i]     = 0;
                    fcyc[i]      = 0;
                    lo_run[i]    = 0;
                    prev_rise[i] = last_rise[i];
                    last_rise[i] = cyc;
                end
                if (sclk[i] && !clk_p[i]) begin
                    if (i == 0) chain[i] = {chain[i][14:0], ser[i]};
                    else        chain[i] = {ser[i], chain[i][15:1]};
                    edges[i]++;
                    check("lo_phase_len", lo_run[i], div_of(i));
                    lo_run[i] = 0;
                end
                if (!sclk[i] && clk_p[i]) begin
                    check("hi_phase_len", hi_run[i], div_of(i));
                    hi_run[i] = 0;
                end
                if (latch[i] && !lat_p[i]) begin
                    check("latch_start", fcyc[i], 2 * div_of(i) * 16);
                    check("edge_count", edges[i], 16);
                    if (exp_q.size() == 0) begin
                        check("unexpected_latch", i, -1);
                    end else begin
                        exp_t e;
                        e = exp_q.pop_front();
                        check("latch_inst", i, int'(e.inst));
                        check("latch_word", int'(chain[i]), int'(e.word));
                    end
                end
                if (!latch[i] && lat_p[i]) begin
                    check("latch_len", lat_run[i], div_of(i));
                    lat_run[i] = 0;
                end
                if (!busy[i] && busy_p[i]) check("busy_len", fcyc[i], 2 * div_of(i) * 16 + div_of(i));
                if (sclk[i]) hi_run[i]++;
                else if (busy[i] && !latch[i]) lo_run[i]++;
                if (latch[i]) lat_run[i]++;
                if (busy[i]) fcyc[i]++;
                clk_p[i]  = sclk[i];
                lat_p[i]  = latch[i];
                busy_p[i] = busy[i];
            end
        end
    end

    task automatic push_exp(input int i, input logic [15:0] w);
        exp_t e;
        e.inst = 2'(i);
        e.word = w;
        exp_q.push_back(e);
    endtask

    task automatic send(input int i, input logic [15:0] w, input bit expect_latch);
        int t;
        t = 0;
        s_data[i]  = w;
        s_valid[i] = 1'b1;
        while (!ready[i] && t < 1000) begin
            @(negedge clk);
            t++;
        end
        if (t >= 1000) check("ready_timeout", 0, 1);
        @(posedge clk);
        if (expect_latch) push_exp(i, w);
        @(negedge clk);
        s_valid[i] = 1'b0;
        check("accepted_busy", int'(busy[i]), 1);
    endtask

    task automatic wait_idle(input int i);
        int t;
        t = 0;
        while (busy[i] && t < 1000) begin
            @(negedge clk);
            t++;
        end
        if (t >= 1000) check("idle_timeout", 0, 1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int   r;
        int   t;
        int   lat_seen;
        logic p;
        n_vec = 0;
        n_bad = 0;
        cyc   = 0;
        for (int i = 0; i < 2; i++) begin
            s_valid[i]   = 1'b0;
            s_data[i]    = '0;
            chain[i]     = '0;
            last_rise[i] = 0;
            prev_rise[i] = 0;
        end
        rst        = 1'b1;
        s_valid[0] = 1'b1;
        s_data[0]  = 16'hA5C3;

        // reset held with a pending frame
        repeat (3) begin
            @(negedge clk);
            for (int i = 0; i < 2; i++) begin
                check("rst_ready", int'(ready[i]), 1);
                check("rst_outputs", int'({busy[i], ser[i], sclk[i], latch[i]}), 0);
            end
        end
        rst = 1'b0;

        send(0, 16'hA5C3, 1'b1);
        wait_idle(0);
        repeat (3) @(negedge clk);

        // inputs wiggled while busy must not disturb the frame
        send(0, 16'h3C5A, 1'b1);
        repeat (20) @(negedge clk);
        s_data[0] = 16'hFFFF;
        for (int k = 0; k < 10; k++) begin
            s_valid[0] = ~s_valid[0];
            @(negedge clk);
        end
        s_valid[0] = 1'b0;
        wait_idle(0);
        repeat (4) begin
            @(negedge clk);
            check("no_second_frame", int'(busy[0]), 0);
        end

        // reset after the 7th rising edge: no latch for the partial frame
        send(0, 16'h5555, 1'b0);
        r = 0;
        t = 0;
        p = sclk[0];
        while (r < 7 && t < 2000) begin
            @(negedge clk);
            if (sclk[0] && !p) r++;
            p = sclk[0];
            t++;
        end
        check("mid_rst_edges", r, 7);
        rst = 1'b1;
        @(negedge clk);
        check("mid_rst_ready", int'(ready[0]), 1);
        check("mid_rst_outputs", int'({busy[0], ser[0], sclk[0], latch[0]}), 0);
        rst = 1'b0;
        lat_seen = 0;
        repeat (150) begin
            @(negedge clk);
            if (latch[0]) lat_seen++;
        end
        check("mid_rst_no_latch", lat_seen, 0);

        // LSB-first single frame
        send(1, 16'h0001, 1'b1);
        wait_idle(1);
        repeat (3) @(negedge clk);

        // back-to-back with s_valid held high
        s_data[1]  = 16'h1234;
        s_valid[1] = 1'b1;
        @(posedge clk);
        push_exp(1, 16'h1234);
        push_exp(1, 16'hFFFF);
        @(negedge clk);
        s_data[1] = 16'hFFFF;
        t = 0;
        while (!ready[1] && t < 1000) begin
            @(negedge clk);
            t++;
        end
        @(negedge clk);
        s_valid[1] = 1'b0;
        check("b2b_second_busy", int'(busy[1]), 1);
        wait_idle(1);
        repeat (3) @(negedge clk);
        check("b2b_period", last_rise[1] - prev_rise[1], 34);

        check("pending_frames", exp_q.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
